// File: rtl/cle_key_reader_if.sv
// Key socket bus between the CLE host-side reader (master) and the serial key device (slave).
interface cle_key_reader_if;
   logic [13:0] ba;
   logic        br_w;
   logic        sser;
   logic        key_clk;
   logic        sdrd;

   modport master (output ba, output br_w, output sser, output key_clk, input sdrd);
   modport slave  (input ba, input br_w, input sser, input key_clk, output sdrd);
endinterface

// File: rtl/cle_key_reader.sv
// CLE key reader: walks the key through its unlock nibble sequence, shifts in NBITS
// response bits from SDRD and compares the assembled word against the expected value.
module cle_key_reader #(
   parameter int unsigned NBITS      = 16,
   parameter int unsigned NUNLOCK    = 4,
   parameter logic [31:0] UNLOCK_SEQ = 32'h0000_28A9,
   parameter logic [3:0]  READ_NIB   = 4'h0,
   parameter int unsigned SETUP_CYC  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [NBITS-1:0]   expect_word,
   cle_key_reader_if.master   key,
   output logic               busy,
   output logic               done,
   output logic               match,
   output logic [NBITS-1:0]   resp
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, FIN} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(SETUP_CYC - 1);
   localparam logic [2:0] IDX_LAST  = 3'(NUNLOCK - 1);
   localparam logic [4:0] BIT_LAST  = 5'(NBITS - 1);

   state_t           state_q, state_nx;
   logic [3:0]       wcnt_q;
   logic [2:0]       idx_q;
   logic [4:0]       bitcnt_q;
   logic             rd_phase_q;
   logic [NBITS-1:0] exp_q;
   logic [NBITS-1:0] resp_q;
   logic             match_q;
   logic [3:0]       nib;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nx;
   end

   always_comb begin
      state_nx    = state_q;
      key.ba      = '0;
      key.br_w    = 1'b0;
      key.sser    = 1'b1;
      key.key_clk = 1'b0;
      nib         = rd_phase_q ? READ_NIB : UNLOCK_SEQ[{idx_q, 2'b00} +: 4];
      case (state_q)
         IDLE: if (start) state_nx = SETUP;
         SETUP: begin
            key.ba   = {2'b01, 4'b0000, nib, 4'b0000};
            key.br_w = 1'b1;
            key.sser = 1'b0;
            if (wcnt_q == WAIT_LAST) state_nx = STROBE;
         end
         STROBE: begin
            key.ba      = {2'b01, 4'b0000, nib, 4'b0000};
            key.br_w    = 1'b1;
            key.sser    = 1'b0;
            key.key_clk = 1'b1;
            state_nx    = GAP;
         end
         GAP: state_nx = (rd_phase_q && bitcnt_q == BIT_LAST) ? FIN : SETUP;
         FIN: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Counters advance in GAP so the address is already stable when the next SETUP begins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q     <= '0;
         idx_q      <= '0;
         bitcnt_q   <= '0;
         rd_phase_q <= 1'b0;
         exp_q      <= '0;
         resp_q     <= '0;
         match_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               exp_q      <= expect_word;
               resp_q     <= '0;
               match_q    <= 1'b0;
               wcnt_q     <= '0;
               idx_q      <= '0;
               bitcnt_q   <= '0;
               rd_phase_q <= 1'b0;
            end
            SETUP: begin
               if (wcnt_q == WAIT_LAST) begin
                  wcnt_q <= '0;
                  if (rd_phase_q) begin
                     for (int unsigned i = 0; i < NBITS; i++)
                        if (bitcnt_q == 5'(i)) resp_q[i] <= key.sdrd;
                  end
               end else begin
                  wcnt_q <= wcnt_q + 4'd1;
               end
            end
            GAP: begin
               if (!rd_phase_q) begin
                  if (idx_q == IDX_LAST) rd_phase_q <= 1'b1;
                  else                   idx_q      <= idx_q + 3'd1;
               end else if (bitcnt_q == BIT_LAST) begin
                  match_q <= (resp_q == exp_q);
               end else begin
                  bitcnt_q <= bitcnt_q + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == FIN);
   assign match = match_q;
   assign resp  = resp_q;

endmodule

// File: tb/tb_cle_key_reader.sv
// Self-checking bench for cle_key_reader: default build plus a minimal build, both driven
// by a behavioural key device model.
module tb_cle_key_reader;

   localparam logic [31:0] UNLOCK_SEQ_REF = 32'h0000_28A9;

   logic        clk;
   logic        rst_n;
   logic        start_a, start_b;
   logic [15:0] exp_a, resp_a;
   logic [0:0]  exp_b, resp_b;
   logic        busy_a, done_a, match_a;
   logic        busy_b, done_b, match_b;

   int n_vec = 0;
   int n_err = 0;

   // Key device model state, one set per DUT
   int          cnt_a, seen_a, cnt_b, seen_b;
   logic [13:0] prev_a, prev_b;
   logic [31:0] word_a, word_b;
   logic [3:0]  nibq_a[$];
   logic [3:0]  nibq_b[$];

   cle_key_reader_if bus_a ();
   cle_key_reader_if bus_b ();

   cle_key_reader u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .expect_word(exp_a), .key(bus_a),
      .busy(busy_a), .done(done_a), .match(match_a), .resp(resp_a)
   );

   cle_key_reader #(.NBITS(1), .NUNLOCK(1), .SETUP_CYC(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .expect_word(exp_b), .key(bus_b),
      .busy(busy_b), .done(done_b), .match(match_b), .resp(resp_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_vec++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
      end
   endtask

   // One negedge step of the key device: protocol checks on strobes, strobe counting,
   // and a valid SDRD bit only on the final setup clock of a read access.
   task automatic key_step(input logic [13:0] ba, input logic br_w, input logic sser,
                           input logic kc, input int nunl, input int scyc,
                           input logic [31:0] word, inout int cnt, inout int seen,
                           inout logic [13:0] prev_ba, output logic sd,
                           output bit stb, output logic [3:0] nib);
      logic [13:0] b;
      b   = ba;
      sd  = 1'($urandom);
      stb = 1'b0;
      nib = b[7:4];
      if (kc) begin
         chk("kc_sser", 32'(sser), 32'd0);
         chk("kc_br_w", 32'(br_w), 32'd1);
         chk("kc_ba_hi", 32'(b[13:12]), 32'd1);
         chk("kc_ba_zero", 32'({b[11:8], b[3:0]}), 32'd0);
         chk("kc_ba_stable", 32'(b), 32'(prev_ba));
         stb = 1'b1;
         cnt++;
         seen = 0;
      end else if (!sser && br_w) begin
         seen++;
         if (seen == scyc && cnt >= nunl) sd = word[cnt - nunl];
      end else begin
         seen = 0;
      end
      prev_ba = b;
   endtask

   initial begin
      logic sd;
      bit stb;
      logic [3:0] nib;
      cnt_a = 0; seen_a = 0; prev_a = '0; word_a = '0;
      cnt_b = 0; seen_b = 0; prev_b = '0; word_b = '0;
      bus_a.sdrd = 1'b0;
      bus_b.sdrd = 1'b0;
      forever begin
         @(negedge clk);
         key_step(bus_a.ba, bus_a.br_w, bus_a.sser, bus_a.key_clk, 4, 2, word_a,
                  cnt_a, seen_a, prev_a, sd, stb, nib);
         bus_a.sdrd = sd;
         if (stb) nibq_a.push_back(nib);
         key_step(bus_b.ba, bus_b.br_w, bus_b.sser, bus_b.key_clk, 1, 1, word_b,
                  cnt_b, seen_b, prev_b, sd, stb, nib);
         bus_b.sdrd = sd;
         if (stb) nibq_b.push_back(nib);
      end
   end

   function automatic logic get_done(input bit sel);
      return sel ? done_b : done_a;
   endfunction
   function automatic logic get_busy(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction
   function automatic logic get_match(input bit sel);
      return sel ? match_b : match_a;
   endfunction
   function automatic logic [31:0] get_resp(input bit sel);
      return sel ? 32'(resp_b) : 32'(resp_a);
   endfunction

   task automatic set_start(input bit sel, input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   task automatic run(input bit sel, input logic [31:0] word, input logic [31:0] expv,
                      input bit repulse);
      int nbits, nunl, lat, n, extra;
      logic [31:0] mask, useq, rexp;
      logic [3:0] q[$];
      logic [3:0] en;
      logic mexp;
      useq  = UNLOCK_SEQ_REF;
      nbits = sel ? 1 : 16;
      nunl  = sel ? 1 : 4;
      lat   = 1 + (nunl + nbits) * ((sel ? 1 : 2) + 2);
      mask  = (32'd1 << nbits) - 32'd1;
      rexp  = word & mask;
      mexp  = ((word & mask) == (expv & mask));
      @(negedge clk);
      if (sel) begin
         word_b = word; cnt_b = 0; nibq_b.delete(); exp_b = expv[0:0];
      end else begin
         word_a = word; cnt_a = 0; nibq_a.delete(); exp_a = expv[15:0];
      end
      set_start(sel, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) set_start(sel, 1'b0);
         if (repulse && n == 10) set_start(sel, 1'b1);
         if (repulse && n == 11) set_start(sel, 1'b0);
      end while (!get_done(sel) && n < lat + 40);
      chk("latency", 32'(n), 32'(lat));
      chk("busy_in_done", 32'(get_busy(sel)), 32'd1);
      chk("resp", get_resp(sel), rexp);
      chk("match", 32'(get_match(sel)), 32'(mexp));
      if (repulse) set_start(sel, 1'b1);
      @(negedge clk);
      set_start(sel, 1'b0);
      chk("busy_after_done", 32'(get_busy(sel)), 32'd0);
      chk("done_width", 32'(get_done(sel)), 32'd0);
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (get_done(sel) || get_busy(sel)) extra++;
      end
      chk("no_rerun", 32'(extra), 32'd0);
      chk("match_hold", 32'(get_match(sel)), 32'(mexp));
      chk("resp_hold", get_resp(sel), rexp);
      q = sel ? nibq_b : nibq_a;
      chk("access_count", 32'(q.size()), 32'(nunl + nbits));
      for (int i = 0; i < q.size(); i++) begin
         en = (i < nunl) ? useq[4*i +: 4] : 4'h0;
         chk("nibble", 32'(q[i]), 32'(en));
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_ba"}, 32'(bus_a.ba), 32'd0);
      chk({tag, "_br_w"}, 32'(bus_a.br_w), 32'd0);
      chk({tag, "_sser"}, 32'(bus_a.sser), 32'd1);
      chk({tag, "_key_clk"}, 32'(bus_a.key_clk), 32'd0);
      chk({tag, "_busy"}, 32'(busy_a), 32'd0);
      chk({tag, "_done"}, 32'(done_a), 32'd0);
      chk({tag, "_match"}, 32'(match_a), 32'd0);
      chk({tag, "_resp"}, 32'(resp_a), 32'd0);
   endtask

   initial begin
      logic [31:0] w, e;
      rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      exp_a = '0; exp_b = '0;
      repeat (3) @(negedge clk);
      chk_reset_a("rst");
      chk("rst_b_sser", 32'(bus_b.sser), 32'd1);
      chk("rst_b_busy", 32'(busy_b), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(1'b0, 32'hA5C3, 32'hA5C3, 1'b0);
      run(1'b0, 32'hA5C3, 32'hA5C2, 1'b0);
      run(1'b0, 32'h3C5A, 32'h3C5A, 1'b1);
      for (int k = 0; k < 6; k++) begin
         w = $urandom & 32'hFFFF;
         e = ($urandom_range(0, 1) != 0) ? w : (w ^ (32'd1 << $urandom_range(0, 15)));
         run(1'b0, w, e, 1'b0);
      end

      // Reset in the middle of the read phase
      @(negedge clk);
      word_a = 32'h1234; cnt_a = 0; exp_a = 16'h1234;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_a("midrst");
      @(negedge clk);
      chk("midrst_no_done", 32'(done_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(1'b0, 32'hBEEF, 32'hBEEF, 1'b0);

      for (int k = 0; k < 4; k++) begin
         w = 32'($urandom_range(0, 1));
         e = 32'($urandom_range(0, 1));
         run(1'b1, w, e, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
